ninjin_burst_loader: RTL and testbench
======================================

Name: ninjin_burst_loader

Overview:
- Bus-side load stage of the ninjin interface; sits directly upstream of the renkon/gobou input memories (common mem_dp write port).
- Accepts a load command (base address, word count), consumes PORT-wide stream beats through a valid/ready handshake, splits each beat into DWIDTH words, and issues one registered memory write per cycle.
- Signals completion with a one-cycle ack so the top-level controller can start the accelerator.

Parameters:
- PORT, 32, stream beat width in bits; must equal 2*DWIDTH.
- DWIDTH, 16, memory word width (fixed-point activation width).
- ADDRWIDTH, 12, memory address width.
- LENWIDTH, 16, width of the word-count field.

Ports:
- clk  in  1  clock
- xrst  in  1  asynchronous active-low reset
- req  in  1  start pulse; sampled only in S_IDLE
- base_addr  in  ADDRWIDTH  first memory address, latched on accepted req
- word_num  in  LENWIDTH  number of DWIDTH words to write, latched on accepted req
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat ready
- s_data  in  PORT  stream beat; word0 = [DWIDTH-1:0], word1 = [PORT-1:DWIDTH]
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRWIDTH  memory write address
- mem_wdata  out  DWIDTH  memory write data
- busy  out  1  high from the cycle after req is accepted until ack is asserted, inclusive of the ack cycle
- ack  out  1  one-cycle completion pulse

Behaviour:
- Reset (xrst=0, asynchronous): state=S_IDLE; s_ready, mem_we, busy, ack = 0; mem_addr, mem_wdata, word counter, pending flag = 0.
- States: S_IDLE, S_LOAD, S_DONE.
- S_IDLE: on req=1, latch base_addr/word_num, clear the counter, and go to S_LOAD (word_num!=0) or S_DONE (word_num==0).
- S_LOAD: s_ready = (state==S_LOAD) && !pending, combinational from registers.
  - On the accepting edge of a beat (s_valid && s_ready): register mem_we=1, mem_addr=base+cnt, mem_wdata=word0, and cnt+=1.
  - If remaining words >= 2 after that write, also latch word1 and set pending.
  - Next edge with pending=1: mem_we=1, mem_addr=base+cnt, mem_wdata=word1, cnt+=1, clear pending. s_ready is low during this cycle.
  - Peak throughput is 1 beat per 2 cycles and 1 word per cycle.
- Odd word_num: word1 of the final beat is discarded and no write is issued for it.
- Write latency: memory write appears on the mem_* registers one cycle after the beat's handshake edge.
- mem_we is 0 in any cycle with no write. mem_addr/mem_wdata hold their last value when mem_we=0.
- Completion: on the edge that issues the final write (cnt reaches word_num), go to S_DONE. The next edge asserts ack=1 for exactly one cycle and returns to S_IDLE. The final write and ack are never in the same cycle.
- word_num==0: req -> S_DONE -> ack one cycle later. No writes, s_ready never asserted.
- Address arithmetic is modulo 2^ADDRWIDTH; base+cnt wraps silently past the top of memory.
- req while busy is ignored; the latched command does not change.
- s_valid while s_ready=0 is held by the source (standard valid/ready). No beat is consumed outside S_LOAD.
- xrst asserted mid-load aborts immediately: no further writes, no ack, a partially consumed beat is dropped.

Optional Feature:
- Macro: NINJIN_SWAP_HALF_EN
- Defined: word order within a beat is reversed. s_data[PORT-1:DWIDTH] is written first; for odd word_num the final beat's low half is discarded.
- Undefined: the order described in Behaviour (low half first).
- Handshake, timing and all counts are identical in both builds.

Test Plan:
- Basic: base_addr=0x010, word_num=4, beats 0x0002_0001 then 0x0004_0003, s_valid always high -> writes (0x010,1),(0x011,2),(0x012,3),(0x013,4) on 4 consecutive cycles; s_ready pattern 1,0,1,0; ack exactly one cycle after the final write; busy low afterwards.
- Odd count: word_num=3, beats 0xBBBB_AAAA and 0xDDDD_CCCC -> exactly 3 writes: AAAA, BBBB, CCCC; DDDD never written; ack follows.
- Backpressure/gaps: word_num=4, s_valid low for 5 cycles between beats -> no mem_we during the gap; addresses remain contiguous; pending never set while idle-waiting.
- Zero/ignored req: word_num=0 -> ack two cycles after req, zero writes. A second req with base=0x100 pulsed mid-load of a word_num=6 command -> ignored; all 6 writes go to the original base.
- Wrap and reset: base=0xFFE, word_num=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. Separately, drop xrst after 1 of 4 writes -> outputs zero immediately, no ack; the next command completes normally.
- NINJIN_SWAP_HALF_EN defined: repeat the basic test -> write data order 2,1,4,3 at the same addresses and cycles.

Source files
------------

// File: rtl/ninjin_burst_loader.sv
// ninjin_burst_loader: bus-side load stage feeding the renkon/gobou input
// memories. Accepts a (base, count) command, consumes PORT-wide stream beats
// and writes them out one DWIDTH word per cycle on a registered mem port.
//
// Build option: NINJIN_SWAP_HALF_EN -- when defined, the high half of each
// beat is written first and, for an odd count, the final beat's low half is
// discarded. Handshake and timing are identical in both builds.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for req; latches command on req
// S_LOAD | accepting beats / writing words until cnt reaches word count
// S_DONE | final write issued; next edge pulses ack and returns to idle
module ninjin_burst_loader #(
    parameter int PORT      = 32,
    parameter int DWIDTH    = 16,
    parameter int ADDRWIDTH = 12,
    parameter int LENWIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 req,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic [LENWIDTH-1:0]  word_num,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PORT-1:0]      s_data,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]    mem_wdata,
    output logic                 busy,
    output logic                 ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [ADDRWIDTH-1:0] base_q;
    logic [LENWIDTH-1:0]  num_q;
    logic [LENWIDTH-1:0]  cnt;
    logic                 pending;
    logic [DWIDTH-1:0]    word1_q;

    logic [LENWIDTH-1:0]  remaining;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0]    first_word;
    logic [DWIDTH-1:0]    second_word;

    // Words still owed before the current write, and its wrapping address.
    assign remaining = num_q - cnt;
    assign wr_addr   = base_q + cnt[ADDRWIDTH-1:0];

`ifdef NINJIN_SWAP_HALF_EN
    assign first_word  = s_data[PORT-1:DWIDTH];
    assign second_word = s_data[DWIDTH-1:0];
`else
    assign first_word  = s_data[DWIDTH-1:0];
    assign second_word = s_data[PORT-1:DWIDTH];
`endif

    // A beat is taken only while loading and no second half is outstanding.
    assign s_ready = (state == S_LOAD) && !pending;

    // Command latch, beat split, write issue and completion sequencing.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            word1_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            ack       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            ack    <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Also drops busy on the edge that ends the ack cycle.
                    busy <= req;
                    if (req) begin
                        base_q  <= base_addr;
                        num_q   <= word_num;
                        cnt     <= '0;
                        pending <= 1'b0;
                        state   <= (word_num == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pending) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= word1_q;
                        cnt       <= cnt + LENWIDTH'(1);
                        pending   <= 1'b0;
                        if (remaining == LENWIDTH'(1)) begin
                            state <= S_DONE;
                        end
                    end else if (s_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= first_word;
                        cnt       <= cnt + LENWIDTH'(1);
                        // Second half is kept only if the count still needs it.
                        if (remaining >= LENWIDTH'(2)) begin
                            word1_q <= second_word;
                            pending <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    ack   <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ninjin_burst_loader.sv
// Directed bench for ninjin_burst_loader: a table of load commands with
// hand-computed write streams, plus hand-written reset-abort and reset checks.
module tb_ninjin_burst_loader;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        req = 1'b0;
    logic [11:0] base_addr = '0;
    logic [15:0] word_num = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        ack;

    ninjin_burst_loader #(
        .PORT(32), .DWIDTH(16), .ADDRWIDTH(12), .LENWIDTH(16)
    ) dut (
        .clk(clk), .xrst(xrst), .req(req), .base_addr(base_addr),
        .word_num(word_num), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .ack(ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write/ack monitor sampled on the falling edge.
    logic [11:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          ack_total = 0;
    int          ack_cyc   = -1;
    int          rdy_viol  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                wr_cyc_q.push_back(cyc);
            end
            if (ack) begin
                ack_total++;
                ack_cyc = cyc;
            end
            if (s_ready && !busy) rdy_viol++;
        end
    end

    typedef struct packed {
        logic [11:0]      base;
        logic [15:0]      num;
        logic [2:0][31:0] beat;
        logic [7:0]       gap;
        logic             spur;
        logic [5:0][11:0] ea;
        logic [5:0][15:0] ed;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [5:0][11:0] a6(input logic [11:0] a, b, c, d, e, f);
        logic [5:0][11:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    function automatic logic [5:0][15:0] d6(input logic [15:0] a, b, c, d, e, f);
        logic [5:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int w0, a0, v0, nb, acc, hs, t, n, last;
        string tag;
        tag = $sformatf("v%0d", id);
        w0 = wr_addr_q.size();
        a0 = ack_total;
        v0 = rdy_viol;
        nb = (int'(v.num) + 1) / 2;
        hs = 0;
        @(negedge clk);
        req = 1'b1; base_addr = v.base; word_num = v.num;
        s_valid = (nb > 0); s_data = v.beat[0];
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; base_addr = 12'h0; word_num = 16'h0;
        acc = cyc;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int b = 0; b < nb; b++) begin
            s_data = v.beat[b];
            s_valid = 1'b1;
            if (v.spur && b == 1) begin
                req = 1'b1; base_addr = 12'h100; word_num = 16'd2;
                @(negedge clk);
                req = 1'b0; base_addr = 12'h0; word_num = 16'h0;
            end
            t = 0;
            while (!s_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check({tag, "_ready_timeout"}, 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            hs++;
            @(negedge clk);
            if (v.gap != 0 && b < nb - 1) begin
                s_valid = 1'b0;
                repeat (int'(v.gap)) @(negedge clk);
            end
        end
        s_valid = 1'b0;
        #1;
        t = 0;
        while (ack_total == a0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({tag, "_ack_seen"}, 32'(ack_total - a0), 32'd1);
        check({tag, "_busy_in_ack"}, 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check({tag, "_ack_one_cycle"}, 32'(ack_total - a0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_beats"}, 32'(hs), 32'(nb));
        check({tag, "_ready_idle"}, 32'(rdy_viol - v0), 32'd0);
        n = wr_addr_q.size() - w0;
        check({tag, "_nwrites"}, 32'(n), 32'(v.num));
        for (int i = 0; i < n && i < int'(v.num) && i < 6; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[w0+i]), 32'(v.ea[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[w0+i]), 32'(v.ed[i]));
        end
        if (v.num == 16'd0) begin
            check({tag, "_ack_latency"}, 32'(ack_cyc), 32'(acc + 1));
        end else if (n > 0) begin
            last = wr_cyc_q[w0+n-1];
            check({tag, "_first_latency"}, 32'(wr_cyc_q[w0]), 32'(acc + 1));
            check({tag, "_ack_after_last"}, 32'(ack_cyc), 32'(last + 1));
            if (v.gap == 0) begin
                check({tag, "_contiguous"}, 32'(last - wr_cyc_q[w0]), 32'(n - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int ws, as;
        vecs[0] = '{base: 12'h010, num: 16'd4, beat: {32'h0, 32'h0004_0003, 32'h0002_0001},
                    gap: 8'd0, spur: 1'b0, ea: a6(12'h010, 12'h011, 12'h012, 12'h013, 12'h0, 12'h0),
`ifdef NINJIN_SWAP_HALF_EN
                    ed: d6(16'h2, 16'h1, 16'h4, 16'h3, 16'h0, 16'h0)};
`else
                    ed: d6(16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0)};
`endif
        vecs[1] = '{base: 12'h020, num: 16'd3, beat: {32'h0, 32'hDDDD_CCCC, 32'hBBBB_AAAA},
                    gap: 8'd0, spur: 1'b0, ea: a6(12'h020, 12'h021, 12'h022, 12'h0, 12'h0, 12'h0),
`ifdef NINJIN_SWAP_HALF_EN
                    ed: d6(16'hBBBB, 16'hAAAA, 16'hDDDD, 16'h0, 16'h0, 16'h0)};
`else
                    ed: d6(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0, 16'h0, 16'h0)};
`endif
        vecs[2] = '{base: 12'h030, num: 16'd4, beat: {32'h0, 32'h0008_0007, 32'h0006_0005},
                    gap: 8'd5, spur: 1'b0, ea: a6(12'h030, 12'h031, 12'h032, 12'h033, 12'h0, 12'h0),
`ifdef NINJIN_SWAP_HALF_EN
                    ed: d6(16'h6, 16'h5, 16'h8, 16'h7, 16'h0, 16'h0)};
`else
                    ed: d6(16'h5, 16'h6, 16'h7, 16'h8, 16'h0, 16'h0)};
`endif
        vecs[3] = '{base: 12'hFFE, num: 16'd4, beat: {32'h0, 32'h00DD_00CC, 32'h00BB_00AA},
                    gap: 8'd0, spur: 1'b0, ea: a6(12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h0, 12'h0),
`ifdef NINJIN_SWAP_HALF_EN
                    ed: d6(16'hBB, 16'hAA, 16'hDD, 16'hCC, 16'h0, 16'h0)};
`else
                    ed: d6(16'hAA, 16'hBB, 16'hCC, 16'hDD, 16'h0, 16'h0)};
`endif
        vecs[4] = '{base: 12'h077, num: 16'd0, beat: {32'h0, 32'h0, 32'h1234_5678},
                    gap: 8'd0, spur: 1'b0, ea: a6(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0),
                    ed: d6(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0)};
        vecs[5] = '{base: 12'h040, num: 16'd6, beat: {32'h0006_0005, 32'h0004_0003, 32'h0002_0001},
                    gap: 8'd0, spur: 1'b1, ea: a6(12'h040, 12'h041, 12'h042, 12'h043, 12'h044, 12'h045),
`ifdef NINJIN_SWAP_HALF_EN
                    ed: d6(16'h2, 16'h1, 16'h4, 16'h3, 16'h6, 16'h5)};
`else
                    ed: d6(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6)};
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy_ack_ready", {29'd0, busy, ack, s_ready}, 32'd0);
        xrst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset mid-load: one write issued, second half pending, then abort.
        @(negedge clk);
        req = 1'b1; base_addr = 12'h050; word_num = 16'd4;
        s_valid = 1'b1; s_data = 32'h0002_0001;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check("abort_first_we", 32'(mem_we), 32'd1);
        check("abort_first_addr", 32'(mem_addr), 32'h050);
        xrst = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        check("abort_busy_ready", {30'd0, busy, s_ready}, 32'd0);
        ws = wr_addr_q.size();
        as = ack_total;
        repeat (3) @(negedge clk);
        xrst = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("abort_no_writes", 32'(wr_addr_q.size() - ws), 32'd0);
        check("abort_no_ack", 32'(ack_total - as), 32'd0);
        run_vec(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
